fetch_queue: RTL and testbench

- Sits between the PC-holding fetch unit and the decode stage.
- Each cycle it decides whether to advance the PC (drives en_pc), issues the instruction-memory read for the current pc, and captures the 1-cycle-latency read data into a small FIFO tagged with its pc.
- Decode consumes entries through a valid/ready handshake.
- Branch/jump redirects pass through to the fetch unit (en_new_pc/new_pc). The same redirect flushes the FIFO and drops any in-flight read.

---
 rtl/fetch_pkg.sv | 19 +
 rtl/sync_fifo.sv | 87 ++++++++
 rtl/fetch_queue.sv | 112 +++++++++++
 tb/tb_fetch_queue.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pkg
//  Description : Shared widths and the FIFO entry type for the fetch queue.
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    localparam int PC_W    = 12;
    localparam int INSTR_W = 32;

    // One captured fetch: the instruction word tagged with the pc it came from.
    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Small single-clock FIFO with synchronous flush. Flush takes
//                priority over push and pop. Pointers wrap modulo DEPTH.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo
    import fetch_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = fetch_entry_t
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    input  T                       wdata_i,
    output T                       rdata_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   empty_o,
    output logic                   full_o
);

    localparam int             AW      = $clog2(DEPTH);
    localparam logic [AW:0]    C_DEPTH = (AW+1)'(DEPTH);

    T              mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0]   count_q,  count_d;
    logic          w_push;
    logic          w_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == C_DEPTH);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // Requests that would overflow or underflow are ignored.
    assign w_push = push_i && !full_o;
    assign w_pop  = pop_i  && !empty_o;

    // Next pointer and occupancy; a flush clears everything regardless of push/pop.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (w_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (w_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (w_push && !w_pop)      count_d = count_q + 1'b1;
            else if (!w_push && w_pop) count_d = count_q - 1'b1;
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; cleared on reset so the head reads as zero while reset is held.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (w_push && !flush_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule : sync_fifo
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_queue
//  Description : Issues instruction-memory reads under a credit scheme,
//                captures the 1-cycle-latency read data into a FIFO tagged
//                with its pc, and hands entries to decode via valid/ready.
//                A redirect passes through to the fetch unit and flushes
//                both the FIFO and any in-flight read.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue #(
    parameter int PC_W    = fetch_pkg::PC_W,
    parameter int INSTR_W = fetch_pkg::INSTR_W,
    parameter int DEPTH   = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [PC_W-1:0]    pc_i,
    output logic               en_pc_o,
    output logic               en_new_pc_o,
    output logic [PC_W-1:0]    new_pc_o,
    output logic               imem_req_o,
    output logic [PC_W-1:0]    imem_addr_o,
    input  logic [INSTR_W-1:0] imem_rdata_i,
    input  logic               redirect_i,
    input  logic [PC_W-1:0]    redirect_pc_i,
    output logic               dec_valid_o,
    output logic [INSTR_W-1:0] dec_instr_o,
    output logic [PC_W-1:0]    dec_pc_o,
    input  logic               dec_ready_i
);

    localparam int          CW      = $clog2(DEPTH) + 1;
    localparam logic [CW:0] C_DEPTH = (CW+1)'(DEPTH);

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } entry_t;

    logic            inflight_q,    inflight_d;
    logic [PC_W-1:0] inflight_pc_q, inflight_pc_d;

    logic [CW-1:0]   w_count;
    logic [CW:0]     w_used;
    logic            w_empty;
    logic            w_full;
    logic            w_issue;
    logic            w_push;
    logic            w_pop;
    entry_t          w_wentry;
    entry_t          w_head;

    // Credits count both stored entries and the read still in flight; a pop in
    // the same cycle is deliberately not credited so the FIFO can never overflow.
    assign w_used  = {1'b0, w_count} + {{CW{1'b0}}, inflight_q};
    assign w_issue = reset_n && !redirect_i && (w_used < C_DEPTH) && !w_full;

    assign imem_req_o  = w_issue;
    assign imem_addr_o = pc_i;
    assign en_pc_o     = w_issue;

    // Redirect is a combinational pass-through, held low while in reset.
    assign en_new_pc_o = reset_n && redirect_i;
    assign new_pc_o    = reset_n ? redirect_pc_i : '0;

    // Read data returns the cycle after issue; a redirect in that cycle discards it.
    assign w_push         = inflight_q && !redirect_i;
    assign w_wentry.pc    = inflight_pc_q;
    assign w_wentry.instr = imem_rdata_i;

    assign dec_valid_o = !w_empty && !redirect_i;
    assign dec_instr_o = w_head.instr;
    assign dec_pc_o    = w_head.pc;
    assign w_pop       = dec_valid_o && dec_ready_i;

    // In-flight tracking: set on an issue edge, cleared otherwise (including redirect).
    always_comb begin
        inflight_d    = w_issue;
        inflight_pc_d = inflight_pc_q;
        if (w_issue) inflight_pc_d = pc_i;
    end

    // In-flight read state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    sync_fifo #(
        .DEPTH (DEPTH),
        .T     (entry_t)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (w_push),
        .pop_i   (w_pop),
        .flush_i (redirect_i),
        .wdata_i (w_wentry),
        .rdata_o (w_head),
        .count_o (w_count),
        .empty_o (w_empty),
        .full_o  (w_full)
    );

endmodule : fetch_queue
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_queue
//  Description : Self-checking bench for fetch_queue with a fetch-unit pc
//                model, a 1-cycle instruction memory returning addr+0x100,
//                and a scoreboard of expected delivered pcs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_queue;

    logic        clk;
    logic        reset_n;
    logic [11:0] pc;
    logic        en_pc;
    logic        en_new_pc;
    logic [11:0] new_pc;
    logic        imem_req;
    logic [11:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [11:0] redirect_pc;
    logic        dec_valid;
    logic [31:0] dec_instr;
    logic [11:0] dec_pc;
    logic        dec_ready;

    int          total;
    int          bad;
    int          n_deliv;
    int          nreq;
    logic [11:0] exp_q [$];

    fetch_queue #(
        .PC_W    (12),
        .INSTR_W (32),
        .DEPTH   (4)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .pc_i          (pc),
        .en_pc_o       (en_pc),
        .en_new_pc_o   (en_new_pc),
        .new_pc_o      (new_pc),
        .imem_req_o    (imem_req),
        .imem_addr_o   (imem_addr),
        .imem_rdata_i  (imem_rdata),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .dec_valid_o   (dec_valid),
        .dec_instr_o   (dec_instr),
        .dec_pc_o      (dec_pc),
        .dec_ready_i   (dec_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Fetch-unit pc register.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n)       pc <= '0;
        else if (en_new_pc) pc <= new_pc;
        else if (en_pc)     pc <= pc + 12'd1;
    end

    // Instruction memory: data = address + 0x100, one cycle after the request.
    always @(posedge clk) begin
        if (imem_req) imem_rdata <= 32'(imem_addr) + 32'h100;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_seq(input logic [11:0] start, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(start + 12'(i));
    endtask

    // Assert reset for two cycles; returns at the start of cycle 0 after release.
    task automatic release_reset();
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
    endtask

    // Scoreboard monitor: every accepted head must match the next expected pc.
    always @(negedge clk) begin
        if (reset_n && dec_valid && dec_ready) begin
            n_deliv++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pop: got pc %h expected none", dec_pc);
            end else begin
                logic [11:0] e;
                e = exp_q.pop_front();
                chk("dec_pc", 32'(dec_pc), 32'(e));
                chk("dec_instr", dec_instr, 32'(e) + 32'h100);
            end
        end
    end

    initial begin
        total = 0; bad = 0; n_deliv = 0; nreq = 0;
        reset_n = 1'b0; dec_ready = 1'b1;
        redirect = 1'b1; redirect_pc = 12'h055;

        // Reset state: all outputs low, address follows pc.
        #2;
        chk("rst_imem_req",  32'(imem_req),  32'd0);
        chk("rst_en_pc",     32'(en_pc),     32'd0);
        chk("rst_en_new_pc", 32'(en_new_pc), 32'd0);
        chk("rst_new_pc",    32'(new_pc),    32'd0);
        chk("rst_dec_valid", 32'(dec_valid), 32'd0);
        chk("rst_dec_pc",    32'(dec_pc),    32'd0);
        chk("rst_dec_instr", dec_instr,      32'd0);
        chk("rst_imem_addr", 32'(imem_addr), 32'(pc));
        redirect = 1'b0;

        // Streaming with ready high: one request per cycle, 2-cycle latency.
        release_reset();
        push_seq(12'h000, 8);
        for (int c = 0; c < 10; c++) begin
            #1;
            if (c < 5) begin
                chk("t1_req",  32'(imem_req),  32'd1);
                chk("t1_addr", 32'(imem_addr), 32'(c));
            end
            if (c == 1) chk("t1_valid_c1", 32'(dec_valid), 32'd0);
            if (c == 2) chk("t1_valid_c2", 32'(dec_valid), 32'd1);
            step();
        end
        chk("t1_drained", 32'(exp_q.size()), 32'd0);

        // Ready low: exactly four requests, then stall until a pop frees a credit.
        dec_ready = 1'b0;
        release_reset();
        nreq = 0;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (imem_req) nreq++;
            if (c >= 4) chk("t2_en_pc_full", 32'(en_pc), 32'd0);
            step();
        end
        chk("t2_nreq", 32'(nreq), 32'd4);
        push_seq(12'h000, 8);
        dec_ready = 1'b1;
        for (int c = 8; c < 16; c++) begin
            #1;
            if (c == 8) chk("t2_noissue_c8", 32'(imem_req), 32'd0);
            if (c == 9) begin
                chk("t2_issue_c9", 32'(imem_req),  32'd1);
                chk("t2_addr_c9",  32'(imem_addr), 32'h004);
            end
            step();
        end
        chk("t2_drained", 32'(exp_q.size()), 32'd0);

        // Single redirect with a read in flight.
        release_reset();
        push_seq(12'h000, 3);
        push_seq(12'h080, 4);
        for (int c = 0; c < 12; c++) begin
            redirect    = (c == 5);
            redirect_pc = 12'h080;
            #1;
            if (c == 5) begin
                chk("t3_en_new_pc", 32'(en_new_pc), 32'd1);
                chk("t3_new_pc",    32'(new_pc),    32'h080);
                chk("t3_dec_valid", 32'(dec_valid), 32'd0);
                chk("t3_req",       32'(imem_req),  32'd0);
                chk("t3_en_pc",     32'(en_pc),     32'd0);
            end
            if (c == 6) begin
                chk("t3_req_new",  32'(imem_req),  32'd1);
                chk("t3_addr_new", 32'(imem_addr), 32'h080);
            end
            step();
        end
        redirect = 1'b0;
        chk("t3_drained", 32'(exp_q.size()), 32'd0);

        // Back-to-back redirects: the second target wins.
        release_reset();
        push_seq(12'h000, 3);
        push_seq(12'h020, 4);
        for (int c = 0; c < 13; c++) begin
            redirect    = (c == 5) || (c == 6);
            redirect_pc = (c == 5) ? 12'h010 : 12'h020;
            #1;
            if (c == 6) begin
                chk("t4_en_new_pc", 32'(en_new_pc), 32'd1);
                chk("t4_new_pc",    32'(new_pc),    32'h020);
                chk("t4_en_pc",     32'(en_pc),     32'd0);
            end
            if (c == 7) chk("t4_addr", 32'(imem_addr), 32'h020);
            step();
        end
        redirect = 1'b0;
        chk("t4_drained", 32'(exp_q.size()), 32'd0);

        // Alternating ready: 32 consecutive pcs, none lost or duplicated.
        n_deliv = 0;
        dec_ready = 1'b1;
        release_reset();
        push_seq(12'h000, 32);
        begin
            int c;
            c = 0;
            while (n_deliv < 32 && c < 300) begin
                dec_ready = (c % 2 == 0);
                step();
                c++;
            end
        end
        chk("t5_delivered", 32'(n_deliv), 32'd32);
        chk("t5_drained", 32'(exp_q.size()), 32'd0);
        dec_ready = 1'b1;

        // Reset mid-stream with count=3 and a read in flight.
        dec_ready = 1'b0;
        release_reset();
        for (int c = 0; c < 4; c++) step();
        #1;
        chk("t6_full_en_pc", 32'(en_pc),     32'd0);
        chk("t6_pre_valid",  32'(dec_valid), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(dec_valid), 32'd0);
        chk("t6_rst_req",   32'(imem_req),  32'd0);
        chk("t6_rst_dpc",   32'(dec_pc),    32'd0);
        chk("t6_rst_instr", dec_instr,      32'd0);
        dec_ready = 1'b1;
        release_reset();
        push_seq(12'h000, 4);
        for (int c = 0; c < 6; c++) step();
        chk("t6_drained", 32'(exp_q.size()), 32'd0);

        reset_n = 1'b0;
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_fetch_queue
`default_nettype wire
